// File: rtl/bcd_disp_pkg.sv
// bcd_disp_pkg: segment patterns, slot and state encodings for the BCD scan display
package bcd_disp_pkg;
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {SLOT_H, SLOT_T, SLOT_U} slot_t;
    typedef enum logic {IDLE, SCAN} state_t;

    function automatic slot_t next_slot(input slot_t s);
        return s == SLOT_H ? SLOT_T : s == SLOT_T ? SLOT_U : SLOT_H;
    endfunction
endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: nibble to {g,f,e,d,c,b,a} segments, dash for non-decimal values
module seg7_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        case (nibble)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_scan_display.sv
// bcd_scan_display: multiplexed 3-digit BCD scanner with leading-zero blanking
module bcd_scan_display
    import bcd_disp_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bcd_valid,
    input  logic [11:0] bcd,
    output logic        bcd_ready,
    output logic [6:0]  seg,
    output logic [2:0]  dig_en,
    output logic        frame_done
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    state_t state, nxt_state;
    slot_t slot, nxt_slot;
    logic [CW-1:0] count, nxt_count;
    logic [11:0] word, nxt_word;
    logic in_reset, last, xfer, blank, lit, frame_d;
    logic [3:0] nib;
    logic [6:0] dec_seg, seg_d;
    logic [2:0] dig_d;

    assign last = count == LAST;
    // in_reset holds ready low for the cycle right after a reset edge
    assign bcd_ready = !in_reset && (state == IDLE || (slot == SLOT_U && last));
    assign xfer = bcd_valid && bcd_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            slot       <= SLOT_H;
            count      <= '0;
            word       <= '0;
            seg        <= {7{SEG_ACTIVE_LOW}};
            dig_en     <= '0;
            frame_done <= 1'b0;
            in_reset   <= 1'b1;
        end else begin
            state      <= nxt_state;
            slot       <= nxt_slot;
            count      <= nxt_count;
            word       <= nxt_word;
            seg        <= seg_d;
            dig_en     <= dig_d;
            frame_done <= frame_d;
            in_reset   <= 1'b0;
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_slot  = slot;
        nxt_count = count;
        nxt_word  = word;
        if (state == IDLE) begin
            if (xfer) begin
                nxt_state = SCAN;
                nxt_slot  = SLOT_H;
                nxt_count = '0;
                nxt_word  = bcd;
            end
        end else if (last) begin
            nxt_slot  = next_slot(slot);
            nxt_count = '0;
            nxt_word  = xfer ? bcd : word;
        end else begin
            nxt_count = count + 1'b1;
        end
    end

    // outputs are decoded from the next state so they register in step with it
    assign nib = nxt_slot == SLOT_H ? nxt_word[11:8] : nxt_slot == SLOT_T ? nxt_word[7:4] : nxt_word[3:0];

    seg7_decode u_dec (
        .nibble (nib),
        .seg    (dec_seg)
    );

    always_comb begin
        blank   = nxt_slot == SLOT_H ? nxt_word[11:8] == 4'd0 : nxt_slot == SLOT_T ? nxt_word[11:4] == 8'd0 : 1'b0;
        lit     = nxt_state == SCAN && !blank;
        dig_d   = !lit ? 3'b000 : nxt_slot == SLOT_H ? 3'b100 : nxt_slot == SLOT_T ? 3'b010 : 3'b001;
        seg_d   = (lit ? dec_seg : SEG_BLANK) ^ {7{SEG_ACTIVE_LOW}};
        frame_d = nxt_state == SCAN && nxt_slot == SLOT_U && nxt_count == LAST;
    end
endmodule

// File: tb/tb_bcd_scan_display.sv
// tb_bcd_scan_display: directed checks of scanning, blanking, handshake, reset and polarity
module tb_bcd_scan_display;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bcd_valid = 1'b0;
    logic [11:0] bcd = '0;
    logic ready, frame, ready_l, frame_l, ready_1, frame_1;
    logic [6:0] seg, seg_l, seg_1;
    logic [2:0] dig, dig_l, dig_1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bcd_scan_display u_dut (.clk(clk), .rst(rst), .bcd_valid(bcd_valid), .bcd(bcd),
        .bcd_ready(ready), .seg(seg), .dig_en(dig), .frame_done(frame));
    bcd_scan_display #(.SEG_ACTIVE_LOW(1'b1)) u_low (.clk(clk), .rst(rst), .bcd_valid(bcd_valid), .bcd(bcd),
        .bcd_ready(ready_l), .seg(seg_l), .dig_en(dig_l), .frame_done(frame_l));
    bcd_scan_display #(.SCAN_DIV(1)) u_div1 (.clk(clk), .rst(rst), .bcd_valid(bcd_valid), .bcd(bcd),
        .bcd_ready(ready_1), .seg(seg_1), .dig_en(dig_1), .frame_done(frame_1));

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        bcd_valid = 1'b0;
        step;
        rst = 1'b0;
        step;
    endtask

    task automatic send(input logic [11:0] w);
        bcd = w;
        bcd_valid = 1'b1;
        step;
        bcd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bcd_valid = 1'b0;
        step;
        step;
        checks += 5;
        if (seg !== 7'b0) begin errors++; $display("FAIL reset_seg: got %b expected %b", seg, 7'b0); end
        if (dig !== 3'b0) begin errors++; $display("FAIL reset_dig: got %b expected %b", dig, 3'b0); end
        if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", frame); end
        if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
        if (seg_l !== 7'b1111111) begin errors++; $display("FAIL reset_seg_low: got %b expected 1111111", seg_l); end
        rst = 1'b0;
        step;
        checks += 3;
        if (ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b expected 1", ready); end
        if (dig !== 3'b0) begin errors++; $display("FAIL idle_dig: got %b expected 000", dig); end
        if (seg_l !== 7'b1111111) begin errors++; $display("FAIL idle_seg_low: got %b expected 1111111", seg_l); end
    endtask

    task automatic test_basic;
        logic [2:0] ed [3] = '{3'b100, 3'b010, 3'b001};
        logic [6:0] es [3] = '{7'b1011011, 7'b1100110, 7'b1001111};
        do_reset;
        send(12'h243);
        for (int i = 1; i <= 12; i++) begin
            int s = (i - 1) / 4;
            checks += 5;
            if (dig !== ed[s]) begin errors++; $display("FAIL basic_dig[%0d]: got %b expected %b", i, dig, ed[s]); end
            if (seg !== es[s]) begin errors++; $display("FAIL basic_seg[%0d]: got %b expected %b", i, seg, es[s]); end
            if (seg_l !== ~es[s]) begin errors++; $display("FAIL basic_seg_low[%0d]: got %b expected %b", i, seg_l, ~es[s]); end
            if (frame !== (i == 12)) begin errors++; $display("FAIL basic_frame[%0d]: got %b expected %b", i, frame, i == 12); end
            if (ready !== (i == 12)) begin errors++; $display("FAIL basic_ready[%0d]: got %b expected %b", i, ready, i == 12); end
            if (i < 12) step;
        end
        step;
        checks += 2;
        if (dig !== 3'b100) begin errors++; $display("FAIL redisplay_dig: got %b expected 100", dig); end
        if (seg !== 7'b1011011) begin errors++; $display("FAIL redisplay_seg: got %b expected 1011011", seg); end
    endtask

    task automatic test_blank;
        logic [2:0] ed [3] = '{3'b000, 3'b000, 3'b001};
        logic [6:0] ea [3] = '{7'b0, 7'b0, 7'b0000111};
        logic [6:0] eb [3] = '{7'b0, 7'b0, 7'b0111111};
        do_reset;
        send(12'h007);
        for (int i = 1; i <= 12; i++) begin
            int s = (i - 1) / 4;
            checks += 2;
            if (dig !== ed[s]) begin errors++; $display("FAIL blank7_dig[%0d]: got %b expected %b", i, dig, ed[s]); end
            if (seg !== ea[s]) begin errors++; $display("FAIL blank7_seg[%0d]: got %b expected %b", i, seg, ea[s]); end
            if (i < 12) step;
        end
        send(12'h000);
        for (int i = 1; i <= 12; i++) begin
            int s = (i - 1) / 4;
            checks += 2;
            if (dig !== ed[s]) begin errors++; $display("FAIL blank0_dig[%0d]: got %b expected %b", i, dig, ed[s]); end
            if (seg !== eb[s]) begin errors++; $display("FAIL blank0_seg[%0d]: got %b expected %b", i, seg, eb[s]); end
            step;
        end
    endtask

    task automatic test_invalid;
        logic [2:0] ed [3] = '{3'b100, 3'b010, 3'b001};
        logic [6:0] es [3] = '{7'b0000110, 7'b1000000, 7'b1101101};
        do_reset;
        send(12'h1A5);
        for (int i = 1; i <= 12; i++) begin
            int s = (i - 1) / 4;
            checks += 2;
            if (dig !== ed[s]) begin errors++; $display("FAIL invalid_dig[%0d]: got %b expected %b", i, dig, ed[s]); end
            if (seg !== es[s]) begin errors++; $display("FAIL invalid_seg[%0d]: got %b expected %b", i, seg, es[s]); end
            step;
        end
    endtask

    task automatic test_back_to_back;
        do_reset;
        send(12'h243);
        for (int i = 1; i <= 12; i++) begin
            if (i == 6) begin
                bcd = 12'h999;
                bcd_valid = 1'b1;
            end
            if (i >= 6) begin
                checks++;
                if (ready !== (i == 12)) begin errors++; $display("FAIL hs_ready[%0d]: got %b expected %b", i, ready, i == 12); end
            end
            if (i >= 5 && i <= 8) begin
                checks++;
                if (seg !== 7'b1100110) begin errors++; $display("FAIL hs_old_seg[%0d]: got %b expected 1100110", i, seg); end
            end
            step;
        end
        bcd_valid = 1'b0;
        checks += 2;
        if (dig !== 3'b100) begin errors++; $display("FAIL hs_new_dig: got %b expected 100", dig); end
        if (seg !== 7'b1101111) begin errors++; $display("FAIL hs_new_seg: got %b expected 1101111", seg); end
        repeat (4) step;
        checks += 2;
        if (dig !== 3'b010) begin errors++; $display("FAIL hs_new_tens_dig: got %b expected 010", dig); end
        if (seg !== 7'b1101111) begin errors++; $display("FAIL hs_new_tens_seg: got %b expected 1101111", seg); end
    endtask

    task automatic test_reset_mid;
        int nf = 0;
        do_reset;
        send(12'h243);
        repeat (5) step;
        checks++;
        if (dig !== 3'b010) begin errors++; $display("FAIL mid_pre_dig: got %b expected 010", dig); end
        rst = 1'b1;
        step;
        checks += 5;
        if (dig !== 3'b000) begin errors++; $display("FAIL mid_dig: got %b expected 000", dig); end
        if (seg !== 7'b0) begin errors++; $display("FAIL mid_seg: got %b expected 0000000", seg); end
        if (frame !== 1'b0) begin errors++; $display("FAIL mid_frame: got %b expected 0", frame); end
        if (ready !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", ready); end
        if (seg_l !== 7'b1111111) begin errors++; $display("FAIL mid_seg_low: got %b expected 1111111", seg_l); end
        rst = 1'b0;
        step;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL mid_ready_after: got %b expected 1", ready); end
        repeat (16) begin
            step;
            if (frame === 1'b1 || dig !== 3'b000) nf++;
        end
        checks++;
        if (nf != 0) begin errors++; $display("FAIL mid_no_frame: got %0d active cycles expected 0", nf); end
    endtask

    task automatic test_rst_priority;
        int nd = 0;
        do_reset;
        bcd = 12'h888;
        bcd_valid = 1'b1;
        rst = 1'b1;
        step;
        rst = 1'b0;
        bcd_valid = 1'b0;
        step;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("FAIL prio_ready: got %b expected 1", ready); end
        repeat (13) begin
            if (dig !== 3'b000) nd++;
            step;
        end
        checks++;
        if (nd != 0) begin errors++; $display("FAIL prio_dropped: got %0d lit cycles expected 0", nd); end
    endtask

    task automatic test_div1;
        logic [2:0] ed [3] = '{3'b100, 3'b010, 3'b001};
        logic [6:0] es [3] = '{7'b1011011, 7'b1100110, 7'b1001111};
        do_reset;
        send(12'h243);
        for (int i = 1; i <= 9; i++) begin
            int s = (i - 1) % 3;
            checks += 4;
            if (dig_1 !== ed[s]) begin errors++; $display("FAIL div1_dig[%0d]: got %b expected %b", i, dig_1, ed[s]); end
            if (seg_1 !== es[s]) begin errors++; $display("FAIL div1_seg[%0d]: got %b expected %b", i, seg_1, es[s]); end
            if (frame_1 !== (s == 2)) begin errors++; $display("FAIL div1_frame[%0d]: got %b expected %b", i, frame_1, s == 2); end
            if (ready_1 !== (s == 2)) begin errors++; $display("FAIL div1_ready[%0d]: got %b expected %b", i, ready_1, s == 2); end
            step;
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_blank;
        test_invalid;
        test_back_to_back;
        test_reset_mid;
        test_rst_priority;
        test_div1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
